// File: rtl/divider_arb.sv
// Round-robin front end that shares one fully pipelined divider between NREQ requesters.
// A tag pipe follows each issued operation so its result can be routed back to the requester that owns it.
module divider_arb #(
    parameter int NREQ = 4,
    parameter int N    = 40,
    parameter int M    = 32,
    parameter int LAT  = 40,
    parameter int QW   = 40
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_vld,
    input  logic [NREQ*N-1:0] req_dividend,
    input  logic [NREQ*M-1:0] req_divisor,
    output logic [NREQ-1:0]   req_gnt,
    output logic              div_data_rdy,
    output logic [N-1:0]      div_dividend,
    output logic [M-1:0]      div_divisor,
    input  logic              div_res_rdy,
    input  logic [QW-1:0]     div_merchant,
    input  logic [M-1:0]      div_remainder,
    output logic [NREQ-1:0]   rsp_vld,
    output logic [QW-1:0]     rsp_merchant,
    output logic [M-1:0]      rsp_remainder,
    output logic              rsp_dz,
    output logic              busy,
    output logic              err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LAT + 2);

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
        logic          dz;
        logic [M-1:0]  lo;
    } tag_t;

    logic [IW-1:0]  r_last;
    logic           r_data_rdy;
    logic [N-1:0]   r_dividend;
    logic [M-1:0]   r_divisor;
    tag_t           r_tag_in;
    tag_t [LAT-1:0] r_tag;
    logic [CW-1:0]  r_cnt;
    logic           r_err;

    logic           w_any;
    logic [IW-1:0]  w_gnt_idx;
    logic [NREQ-1:0] w_gnt;
    logic [N-1:0]   w_sel_dividend;
    logic [M-1:0]   w_sel_divisor;
    tag_t           w_tag;
    logic           w_retire;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && req_vld[(int'(r_last) + 1 + k) % NREQ]) begin
                w_any     = 1'b1;
                w_gnt_idx = IW'((int'(r_last) + 1 + k) % NREQ);
            end
        end
        if (w_any) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign req_gnt        = w_gnt;
    assign w_sel_dividend = req_dividend[w_gnt_idx*N +: N];
    assign w_sel_divisor  = req_divisor[w_gnt_idx*M +: M];
    assign w_tag          = r_tag[LAT-1];
    assign w_retire       = w_tag.vld;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last     <= IW'(NREQ - 1);
            r_data_rdy <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_tag_in   <= '0;
            r_tag      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_data_rdy <= w_any;
            r_tag_in   <= '0;
            if (w_any) begin
                r_last     <= w_gnt_idx;
                r_dividend <= w_sel_dividend;
                r_divisor  <= w_sel_divisor;
                r_tag_in   <= '{vld: 1'b1, idx: w_gnt_idx, dz: (w_sel_divisor == '0),
                                lo: M'(w_sel_dividend)};
            end
            // r_tag_in lines up with div_data_rdy; LAT more stages line up with div_res_rdy.
            r_tag[0] <= r_tag_in;
            for (int k = 1; k < LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            case ({w_any, w_retire})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (div_res_rdy != w_tag.vld) begin
                r_err <= 1'b1;
            end
        end
    end

    assign div_data_rdy = r_data_rdy;
    assign div_dividend = r_dividend;
    assign div_divisor  = r_divisor;

    always_comb begin
        rsp_vld = '0;
        if (div_res_rdy && w_tag.vld) begin
            rsp_vld[w_tag.idx] = 1'b1;
        end
    end

    // A zero divisor returns all-ones and passes the dividend through as remainder.
    assign rsp_dz        = w_tag.vld & w_tag.dz;
    assign rsp_merchant  = rsp_dz ? {QW{1'b1}} : div_merchant;
    assign rsp_remainder = rsp_dz ? w_tag.lo : div_remainder;
    assign busy          = (r_cnt != '0);
    assign err           = r_err;
endmodule

// File: doc/divider_arb.md
DIVIDER_ARB -- requirements
Module: divider_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters sharing one divider_man instance.
REQ-002 SHALL have parameter N, default 40, meaning dividend width.
REQ-003 SHALL have parameter M, default 32, meaning divisor/remainder width.
REQ-004 SHALL have parameter LAT, default 40, meaning divider latency in cycles from div_data_rdy to div_res_rdy.
REQ-005 SHALL have parameter QW, default 40, meaning quotient width.
REQ-006 SHALL have port clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-007 SHALL have port rstn  input  1  meaning reset, asynchronous and active-low.
REQ-008 SHALL have port req_vld  input  NREQ  meaning per-requester operation request; held high until granted.
REQ-009 SHALL have port req_dividend  input  NREQ*N  meaning packed dividends; requester i occupies bits [i*N +: N].
REQ-010 SHALL have port req_divisor  input  NREQ*M  meaning packed divisors; requester i occupies bits [i*M +: M].
REQ-011 SHALL have port req_gnt  output  NREQ  meaning one-hot combinational grant; the request is consumed in this cycle.
REQ-012 SHALL have port div_data_rdy, div_dividend, div_divisor  output  1/N/M  meaning registered issue to the divider.
REQ-013 SHALL have port div_res_rdy, div_merchant, div_remainder  input  1/QW/M  meaning the divider result.
REQ-014 SHALL have port rsp_vld  output  NREQ  meaning one-hot result strobe for the owning requester.
REQ-015 SHALL have port rsp_merchant, rsp_remainder, rsp_dz  output  QW/M/1  meaning the shared result bus; rsp_dz means the divisor was zero.
REQ-016 SHALL have port busy  output  1  meaning at least one operation is in flight.
REQ-017 SHALL have port err  output  1  meaning sticky tag/result misalignment flag.

Function
REQ-018 SHALL grant at most one requester per cycle, round-robin: priority starts at requester (last_grant+1) mod NREQ.
REQ-019 SHALL update last_grant only in cycles where a grant is issued.
REQ-020 SHALL assert req_gnt whenever any req_vld is high; the divider is fully pipelined and issue is never stalled.
REQ-021 SHALL register the granted operands into div_dividend/div_divisor with div_data_rdy=1 on the next edge; div_data_rdy=0 in cycles with no grant, with operands holding their last value.
REQ-022 SHALL push a tag {valid, requester index, dz=(divisor==0)} into a LAT-deep shift register aligned with div_data_rdy.
REQ-023 SHALL drive the tag-pipe output on the cycle div_res_rdy is expected, i.e. LAT cycles after div_data_rdy.
REQ-024 SHALL combinationally forward div_merchant/div_remainder to rsp_merchant/rsp_remainder and set rsp_vld[tag.idx]=div_res_rdy&tag.valid.
REQ-025 SHALL, when rsp_dz=1, force rsp_merchant to all-ones and rsp_remainder to the dividend's low M bits carried in the tag pipe.
REQ-026 SHALL set err (sticky until reset) when div_res_rdy differs from tag.valid in any cycle; rsp_vld is still gated by tag.valid.
REQ-027 SHALL keep an in-flight counter of width clog2(LAT+2): +1 on issue, -1 on tagged result, both in one cycle leaves it unchanged; busy = (count!=0).
REQ-028 SHALL provide no result backpressure; requesters accept rsp_vld unconditionally.
REQ-029 SHALL have one-cycle throughput; total latency from grant to rsp_vld is LAT+1 cycles.

Reset
REQ-030 SHALL, on rstn low, asynchronously clear div_data_rdy, the tag pipe, the counter, err and last_grant (last_grant=NREQ-1, so requester 0 wins first).
REQ-031 SHALL drop operations in flight at reset and produce no rsp_vld for them; divider_man shares rstn.
REQ-032 SHALL reset operand registers to 0; with tag pipe cleared, rsp_vld=0 and busy=0 out of reset.

Verification
REQ-033 SHALL verify: req0 = 29/5 at cycle 0 -> rsp_vld=0001 at cycle 41 with merchant=5, remainder=4, rsp_dz=0.
REQ-034 SHALL verify: all four req_vld held high for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_vld follows the same order from cycle 41 on back-to-back cycles.
REQ-035 SHALL verify: req2 = 100/0 -> rsp_vld=0100 after 41 cycles with rsp_dz=1 and merchant all-ones.
REQ-036 SHALL verify: rstn pulsed low 10 cycles after 3 issues -> busy=0 immediately, no rsp_vld ever appears, next grant goes to req0.
REQ-037 SHALL verify: a model injects a spurious div_res_rdy with an empty tag -> err=1 and stays 1 until reset, with rsp_vld=0.
REQ-038 SHALL verify: issue and retire in the same cycle -> the counter stays unchanged and busy stays 1.
